// File: rtl/gf16_pkg.sv
// Shared types and constants for GF(2^4) arithmetic in the SubBytes datapath.
// Field elements are polynomial-basis nibbles: bit i holds the coefficient of x^i.
package gf16_pkg;

    typedef logic [3:0] gf16_t;

    localparam gf16_t GF16_POLY_AES = 4'b0011;
    localparam gf16_t GF16_ZERO     = 4'b0000;
    localparam gf16_t GF16_ONE      = 4'b0001;

    // Only the three irreducible monic quartics over GF(2) give a field.
    function automatic logic gf16_poly_legal(input gf16_t poly);
        return (poly == 4'b0011) || (poly == 4'b1001) || (poly == 4'b1111);
    endfunction

endpackage

// File: rtl/gf16_mul_core.sv
// Combinational GF(2^4) multiplier.
// Forms the carry-less product of a and b, then folds terms x^6..x^4 back down through POLY.
module gf16_mul_core
    import gf16_pkg::*;
#(
    parameter gf16_t POLY = GF16_POLY_AES
) (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] p
);

    if (!gf16_poly_legal(POLY)) begin : g_bad_poly
        $error("gf16_mul_core: POLY is not an irreducible quartic");
    end

    localparam logic [6:0] RED_BASE = {2'b00, 1'b1, POLY};

    logic [6:0] prod;

    always_comb begin
        prod = '0;
        for (int j = 0; j < 4; j++) begin
            prod = prod ^ ({3'b000, a & {4{b[j]}}} << j);
        end
        // Highest first: each fold can set lower bits that still need reducing.
        // Including the implicit x^4 term clears the bit being folded.
        for (int k = 6; k >= 4; k--) begin
            if (prod[k]) begin
                prod = prod ^ (RED_BASE << (k - 4));
            end
        end
        p = prod[3:0];
    end

endmodule

// File: rtl/gf16_mul.sv
// GF(2^4) multiplier with a zero-latency product and a one-cycle registered copy.
// mul_q holds its last captured value whenever in_valid is low.
module gf16_mul
    import gf16_pkg::*;
#(
    parameter gf16_t POLY = GF16_POLY_AES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    input  logic       in_valid,
    output logic [3:0] mul_out,
    output logic [3:0] mul_q,
    output logic       out_valid
);

    gf16_mul_core #(
        .POLY (POLY)
    ) u_core (
        .a (in1),
        .b (in2),
        .p (mul_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_q     <= GF16_ZERO;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                mul_q <= mul_out;
            end
        end
    end

endmodule

// File: tb/tb_gf16_mul.sv
// Self-checking bench for gf16_mul: directed vectors, exhaustive sweep, pipeline and reset behaviour.
// Reference products come from a shift-and-reduce model over x^4+x+1 written with integer arithmetic.
module tb_gf16_mul;

    logic       clk;
    logic       rst;
    logic [3:0] in1;
    logic [3:0] in2;
    logic       in_valid;
    logic [3:0] mul_out;
    logic [3:0] mul_q;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [3:0] tbl [16][16];

    gf16_mul dut (
        .clk       (clk),
        .rst       (rst),
        .in1       (in1),
        .in2       (in2),
        .in_valid  (in_valid),
        .mul_out   (mul_out),
        .mul_q     (mul_q),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] ref_mul(input int a, input int b);
        int acc = 0;
        int sh  = a;
        for (int i = 0; i < 4; i++) begin
            if (((b >> i) & 1) != 0) acc = acc ^ sh;
            sh = sh << 1;
            if ((sh & 16) != 0) sh = sh ^ 'h13;
        end
        return 4'(acc);
    endfunction

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int a, input int b, input logic v);
        in1      = 4'(a);
        in2      = 4'(b);
        in_valid = v;
    endtask

    initial begin
        logic [3:0] exp_q;
        logic       exp_v;
        int         ra;
        int         rb;
        logic       rv;
        int         inv_cnt;

        rst = 1'b1;
        drive(0, 0, 1'b0);
        #2;
        check("reset_mul_q", mul_q, 4'h0);
        check("reset_out_valid", {3'b000, out_valid}, 4'h0);

        // Inputs present during reset must not be captured.
        drive(5, 8, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("reset_no_capture_q", mul_q, 4'h0);
        check("reset_no_capture_v", {3'b000, out_valid}, 4'h0);
        check("comb_in_reset_5x8", mul_out, 4'd14);

        drive(0, 0, 1'b0);
        rst = 1'b0;

        drive(5, 8, 1'b0);   #1; check("comb_5x8", mul_out, 4'd14);
        drive(15, 15, 1'b0); #1; check("comb_15x15", mul_out, 4'd10);
        drive(2, 9, 1'b0);   #1; check("comb_2x9", mul_out, 4'd1);
        drive(9, 2, 1'b0);   #1; check("comb_9x2", mul_out, 4'd1);

        for (int k = 0; k < 16; k++) begin
            drive(0, k, 1'b0); #1;
            check($sformatf("zero_0x%0d", k), mul_out, 4'h0);
            drive(1, k, 1'b0); #1;
            check($sformatf("ident_1x%0d", k), mul_out, 4'(k));
        end

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(a, b, 1'b0); #1;
                tbl[a][b] = mul_out;
                check($sformatf("sweep_%0dx%0d", a, b), mul_out, ref_mul(a, b));
            end
        end
        for (int a = 0; a < 16; a++) begin
            for (int b = a + 1; b < 16; b++) begin
                check($sformatf("commute_%0d_%0d", a, b), tbl[a][b], tbl[b][a]);
            end
        end
        for (int a = 1; a < 16; a++) begin
            inv_cnt = 0;
            for (int b = 0; b < 16; b++) begin
                if (tbl[a][b] == 4'h1) inv_cnt++;
            end
            check($sformatf("inverse_count_%0d", a), 4'(inv_cnt), 4'h1);
        end

        @(negedge clk);
        check("idle_hold_q", mul_q, 4'h0);
        check("idle_hold_v", {3'b000, out_valid}, 4'h0);

        // Pipeline pattern: valid 1,1,0,1 -> mul_q 14,10,10,1.
        drive(5, 8, 1'b1);
        @(negedge clk);
        check("pipe0_q", mul_q, 4'd14);
        check("pipe0_v", {3'b000, out_valid}, 4'h1);
        drive(15, 15, 1'b1);
        @(negedge clk);
        check("pipe1_q", mul_q, 4'd10);
        check("pipe1_v", {3'b000, out_valid}, 4'h1);
        drive(3, 7, 1'b0);
        @(negedge clk);
        check("pipe2_q_hold", mul_q, 4'd10);
        check("pipe2_v", {3'b000, out_valid}, 4'h0);
        drive(2, 9, 1'b1);
        @(negedge clk);
        check("pipe3_q", mul_q, 4'd1);
        check("pipe3_v", {3'b000, out_valid}, 4'h1);

        exp_q = 4'd1;
        exp_v = 1'b1;
        for (int n = 0; n < 300; n++) begin
            ra = int'($urandom_range(15));
            rb = int'($urandom_range(15));
            rv = 1'($urandom_range(1));
            drive(ra, rb, rv);
            #1;
            check($sformatf("rand_comb_%0d", n), mul_out, ref_mul(ra, rb));
            @(negedge clk);
            exp_v = rv;
            if (rv) exp_q = ref_mul(ra, rb);
            check($sformatf("rand_q_%0d", n), mul_q, exp_q);
            check($sformatf("rand_v_%0d", n), {3'b000, out_valid}, {3'b000, exp_v});
        end

        // Make sure out_valid is high, then hit reset between edges.
        drive(7, 11, 1'b1);
        @(negedge clk);
        check("pre_reset_q", mul_q, ref_mul(7, 11));
        check("pre_reset_v", {3'b000, out_valid}, 4'h1);
        #2;
        rst = 1'b1;
        #1;
        check("async_reset_q", mul_q, 4'h0);
        check("async_reset_v", {3'b000, out_valid}, 4'h0);
        check("async_reset_comb", mul_out, ref_mul(7, 11));
        drive(12, 6, 1'b1);
        #1;
        check("reset_comb_tracks", mul_out, ref_mul(12, 6));
        @(negedge clk);
        check("reset_held_q", mul_q, 4'h0);
        check("reset_held_v", {3'b000, out_valid}, 4'h0);

        drive(12, 6, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_idle_q", mul_q, 4'h0);
        check("post_reset_idle_v", {3'b000, out_valid}, 4'h0);
        drive(15, 15, 1'b1);
        @(negedge clk);
        check("post_reset_cap_q", mul_q, 4'd10);
        check("post_reset_cap_v", {3'b000, out_valid}, 4'h1);
        drive(0, 0, 1'b0);
        @(negedge clk);
        check("post_reset_drop_v", {3'b000, out_valid}, 4'h0);
        check("post_reset_hold_q", mul_q, 4'd10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
